// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 memory path.
// Used by the memory access controller and its bus driver.
package slc3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_WAIT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        IO_ACC,
        DONE
    } mem_state_t;

    localparam logic [15:0] IO_ADDR = 16'hFFFF;
    localparam int WAIT_CYCLES_DEF = 2;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Sequencer <-> memory controller request/done handshake.
// Requests are held by the sequencer until done pulses.
interface mem_access_ctrl_if;

    logic        rd_req;
    logic        wr_req;
    logic [15:0] mar;
    logic [15:0] mdr_out;
    logic [15:0] rd_data;
    logic        done;
    logic        busy;

    modport master (
        output rd_req, wr_req, mar, mdr_out,
        input  rd_data, done, busy
    );

    modport slave (
        input  rd_req, wr_req, mar, mdr_out,
        output rd_data, done, busy
    );

endinterface

// File: rtl/tristate_buf16.sv
// 16-bit bus driver with output enable and registered capture.
// Also owns the check that we never fight the SRAM on reads.
module tristate_buf16 (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        oe,
    input  logic        rd_en,
    input  logic [15:0] dout,
    input  logic        cap_en,
    input  logic        ld_en,
    input  logic [15:0] ld_d,
    output logic [15:0] q,
    inout  wire  [15:0] pad
);

    assign pad = oe ? dout : 16'hzzzz;

    // Hold the last read result: bus capture or the I/O side value.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            q <= 16'h0000;
        end else if (cap_en) begin
            q <= pad;
        end else if (ld_en) begin
            q <= ld_d;
        end
    end

    no_bus_fight: assert property (
        @(posedge Clk) disable iff (!Reset) !(oe && rd_en)
    );

endmodule

// File: rtl/mem_access_ctrl.sv
// SRAM / memory-mapped I/O access controller with wait states.
// Holds each access until a one-cycle done strobe.
module mem_access_ctrl #(
    parameter int          ADDR_W      = 20,
    parameter int          WAIT_CYCLES = slc3_pkg::WAIT_CYCLES_DEF,
    parameter logic [15:0] IO_ADDR     = slc3_pkg::IO_ADDR
) (
    input  logic              Clk,
    input  logic              Reset,
    mem_access_ctrl_if.slave  sq,
    input  logic [15:0]       switches,
    output logic [15:0]       hex_reg,
    output logic              CE_N,
    output logic              UB_N,
    output logic              LB_N,
    output logic              OE_N,
    output logic              WE_N,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [15:0]       Data
);

    import slc3_pkg::*;

    localparam logic [3:0] CNT_LD = 4'(WAIT_CYCLES - 1);

    mem_state_t  state;
    logic [3:0]  cnt;
    logic        is_wr;
    logic [15:0] wdata;
    logic        drv;
    logic        done_q;
    logic        busy_q;
    logic        cap_bus;
    logic        cap_io;
    logic [15:0] rd_q;

    assign cap_bus    = (state == RD_WAIT) && (cnt == 4'd0);
    assign cap_io     = (state == IO_ACC) && !is_wr;
    assign sq.done    = done_q;
    assign sq.busy    = busy_q;
    assign sq.rd_data = rd_q;

    // Access sequencer; every bus strobe is a registered output.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            is_wr   <= 1'b0;
            wdata   <= 16'h0000;
            drv     <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            hex_reg <= 16'h0000;
            ADDR    <= '0;
            CE_N    <= 1'b1;
            UB_N    <= 1'b1;
            LB_N    <= 1'b1;
            OE_N    <= 1'b1;
            WE_N    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sq.wr_req || sq.rd_req) begin
                        ADDR   <= {{(ADDR_W-16){1'b0}}, sq.mar};
                        wdata  <= sq.mdr_out;
                        is_wr  <= sq.wr_req;
                        busy_q <= 1'b1;
                        if (sq.mar == IO_ADDR) begin
                            state <= IO_ACC;
                        end else if (sq.wr_req) begin
                            state <= WR_SETUP;
                            CE_N  <= 1'b0;
                            UB_N  <= 1'b0;
                            LB_N  <= 1'b0;
                            drv   <= 1'b1;
                        end else begin
                            state <= RD_SETUP;
                            CE_N  <= 1'b0;
                            UB_N  <= 1'b0;
                            LB_N  <= 1'b0;
                            OE_N  <= 1'b0;
                        end
                    end
                end
                RD_SETUP: begin
                    cnt   <= CNT_LD;
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (cnt == 4'd0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        CE_N   <= 1'b1;
                        UB_N   <= 1'b1;
                        LB_N   <= 1'b1;
                        OE_N   <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_SETUP: begin
                    cnt   <= CNT_LD;
                    WE_N  <= 1'b0;
                    state <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt == 4'd0) begin
                        WE_N  <= 1'b1;
                        state <= WR_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_HOLD: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                    drv    <= 1'b0;
                    CE_N   <= 1'b1;
                    UB_N   <= 1'b1;
                    LB_N   <= 1'b1;
                end
                IO_ACC: begin
                    if (is_wr) begin
                        hex_reg <= wdata;
                    end
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    tristate_buf16 u_dbuf (
        .Clk    (Clk),
        .Reset  (Reset),
        .oe     (drv),
        .rd_en  (!OE_N),
        .dout   (wdata),
        .cap_en (cap_bus),
        .ld_en  (cap_io),
        .ld_d   (switches),
        .q      (rd_q),
        .pad    (Data)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small SRAM model.
// Expected values are hand-derived cycle counts and data.
module tb_mem_access_ctrl;

    logic        Clk;
    logic        Reset;
    logic [15:0] switches;
    logic [15:0] hex_reg;
    logic        CE_N, UB_N, LB_N, OE_N, WE_N;
    logic [19:0] ADDR;
    wire  [15:0] Data;

    mem_access_ctrl_if sq ();

    mem_access_ctrl dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .sq       (sq),
        .switches (switches),
        .hex_reg  (hex_reg),
        .CE_N     (CE_N),
        .UB_N     (UB_N),
        .LB_N     (LB_N),
        .OE_N     (OE_N),
        .WE_N     (WE_N),
        .ADDR     (ADDR),
        .Data     (Data)
    );

    logic [15:0] mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_a;
    logic [15:0] pl_d;

    assign Data = (!OE_N && !CE_N) ? mem[ADDR[9:0]] : 16'hzzzz;

    // SRAM model: preload port plus write on WE_N low.
    always @(posedge Clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (!WE_N && !CE_N) mem[ADDR[9:0]] <= Data;
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;
    int t_done, t_done2, n_oe, n_we, n_ce, n_done, n_drv;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic floating(input logic [15:0] v);
        return (v === 16'hzzzz) || (v === 16'h0000);
    endfunction

    // Issue one request at a negedge and watch ncyc cycles.
    task automatic access(input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] d,
                          input int hold, input int ncyc);
        int drop_at;
        drop_at = -1;
        t_done = 0; t_done2 = 0; n_oe = 0; n_we = 0;
        n_ce = 0; n_done = 0; n_drv = 0;
        sq.rd_req = rd; sq.wr_req = wr;
        sq.mar = a; sq.mdr_out = d;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (!OE_N) n_oe++;
            if (!WE_N) n_we++;
            if (!CE_N) n_ce++;
            if (OE_N && Data === d) n_drv++;
            if (sq.done) begin
                n_done++;
                if (t_done == 0) t_done = c;
                else t_done2 = c;
                if (drop_at < 0) drop_at = c + hold;
            end
            if (c == drop_at) begin
                sq.rd_req = 1'b0;
                sq.wr_req = 1'b0;
            end
        end
        sq.rd_req = 1'b0;
        sq.wr_req = 1'b0;
    endtask

    initial begin
        Reset = 1'b0;
        sq.rd_req = 1'b0; sq.wr_req = 1'b0;
        sq.mar = 16'h0000; sq.mdr_out = 16'h0000;
        switches = 16'h00A5;
        pl_en = 1'b0; pl_a = 10'h000; pl_d = 16'h0000;

        @(negedge Clk);
        pl_en = 1'b1; pl_a = 10'h042; pl_d = 16'h1234;
        @(negedge Clk);
        pl_en = 1'b0;
        @(negedge Clk);

        chk("rst_busy", 32'(sq.busy), 32'd0);
        chk("rst_done", 32'(sq.done), 32'd0);
        chk("rst_strobes", 32'({CE_N, UB_N, LB_N, OE_N, WE_N}), 32'h1F);
        chk("rst_addr", 32'(ADDR), 32'h0);
        chk("rst_rd_data", 32'(sq.rd_data), 32'h0);
        chk("rst_hex", 32'(hex_reg), 32'h0);
        chk("rst_data_z", 32'(floating(Data)), 32'd1);

        Reset = 1'b1;
        @(negedge Clk);

        access(1'b1, 1'b0, 16'h0042, 16'h0000, 0, 8);
        chk("rd_done_cyc", 32'(t_done), 32'd4);
        chk("rd_oe_cycles", 32'(n_oe), 32'd3);
        chk("rd_ce_cycles", 32'(n_ce), 32'd3);
        chk("rd_we_cycles", 32'(n_we), 32'd0);
        chk("rd_done_pulses", 32'(n_done), 32'd1);
        chk("rd_data", 32'(sq.rd_data), 32'h1234);
        chk("rd_addr", 32'(ADDR), 32'h00042);

        access(1'b0, 1'b1, 16'h0100, 16'hBEEF, 0, 8);
        chk("wr_done_cyc", 32'(t_done), 32'd5);
        chk("wr_we_cycles", 32'(n_we), 32'd2);
        chk("wr_data_cycles", 32'(n_drv), 32'd4);
        chk("wr_oe_cycles", 32'(n_oe), 32'd0);
        chk("wr_mem", 32'(mem[10'h100]), 32'hBEEF);
        chk("wr_data_z", 32'(floating(Data)), 32'd1);

        access(1'b1, 1'b0, 16'h0100, 16'h0000, 0, 8);
        chk("rb_done_cyc", 32'(t_done), 32'd4);
        chk("rb_data", 32'(sq.rd_data), 32'hBEEF);

        access(1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, 5);
        chk("io_rd_done_cyc", 32'(t_done), 32'd2);
        chk("io_rd_data", 32'(sq.rd_data), 32'h00A5);
        chk("io_rd_ce", 32'(n_ce + n_oe + n_we), 32'd0);

        access(1'b0, 1'b1, 16'hFFFF, 16'h3C3C, 0, 5);
        chk("io_wr_done_cyc", 32'(t_done), 32'd2);
        chk("io_wr_hex", 32'(hex_reg), 32'h3C3C);
        chk("io_wr_ce", 32'(n_ce + n_we), 32'd0);
        chk("io_wr_rd_keep", 32'(sq.rd_data), 32'h00A5);

        access(1'b1, 1'b1, 16'h0010, 16'h5A5A, 0, 8);
        chk("both_we_cycles", 32'(n_we), 32'd2);
        chk("both_oe_cycles", 32'(n_oe), 32'd0);
        chk("both_mem", 32'(mem[10'h010]), 32'h5A5A);
        chk("both_done_cyc", 32'(t_done), 32'd5);

        access(1'b1, 1'b0, 16'h0042, 16'h0000, 2, 12);
        chk("hold_pulses", 32'(n_done), 32'd2);
        chk("hold_first", 32'(t_done), 32'd4);
        chk("hold_second", 32'(t_done2), 32'd9);
        chk("hold_data", 32'(sq.rd_data), 32'h1234);

        sq.rd_req = 1'b1; sq.mar = 16'h0100;
        @(posedge Clk); @(negedge Clk);
        @(posedge Clk); @(negedge Clk);
        chk("mid_oe_low", 32'(OE_N), 32'd0);
        Reset = 1'b0;
        sq.rd_req = 1'b0;
        #1;
        chk("ar_busy", 32'(sq.busy), 32'd0);
        chk("ar_oe", 32'(OE_N), 32'd1);
        chk("ar_ce", 32'(CE_N), 32'd1);
        chk("ar_data_z", 32'(floating(Data)), 32'd1);
        chk("ar_rd_data", 32'(sq.rd_data), 32'h0);
        chk("ar_hex", 32'(hex_reg), 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); @(negedge Clk);
        @(posedge Clk); @(negedge Clk);
        chk("post_busy", 32'(sq.busy), 32'd0);
        chk("post_done", 32'(sq.done), 32'd0);
        chk("post_oe", 32'(OE_N), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
